// File: rtl/spi_rx_frontend_if.sv
// -----------------------------------------------------------------------------
// spi_rx_frontend_if
// Bundles the SPI receive front-end bus: raw SPI pins and transmitter status in,
// decoded command and metadata strobes out. Clock and reset are plain ports on
// the module and are not part of this bundle.
//
//   sclk, cs, mosi    raw SPI clock, active-low chip select, serial data
//   transmitting      transmitter busy; bytes completed meanwhile are dropped
//   query_metadata    one-cycle request to stream the metadata table
//   xmit_idle         transmitter can accept a metadata byte
//   sync_sclk/sync_cs synchronized copies of sclk/cs
//   op, data          last opcode and 32-bit argument
//   execute           one-cycle command-valid strobe
//   writeMeta         one-cycle metadata byte strobe, byte on meta_data
//
// Modports: master = stimulus side, slave = the front-end.
// -----------------------------------------------------------------------------
interface spi_rx_frontend_if;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        transmitting;
    logic        query_metadata;
    logic        xmit_idle;
    logic        sync_sclk;
    logic        sync_cs;
    logic [7:0]  op;
    logic [31:0] data;
    logic        execute;
    logic        writeMeta;
    logic [7:0]  meta_data;

    modport master (
        output sclk, cs, mosi, transmitting, query_metadata, xmit_idle,
        input  sync_sclk, sync_cs, op, data, execute, writeMeta, meta_data
    );

    modport slave (
        input  sclk, cs, mosi, transmitting, query_metadata, xmit_idle,
        output sync_sclk, sync_cs, op, data, execute, writeMeta, meta_data
    );
endinterface

// File: rtl/spi_rx_frontend.sv
// -----------------------------------------------------------------------------
// spi_rx_frontend
// Receives SPI command frames (opcode byte, plus four LSB-first argument bytes
// when opcode bit 7 is set) and pulses execute when a command is complete.
// Optionally streams a fixed 27-byte metadata table to a byte transmitter.
//
// Ports:
//   clock     rising-edge system clock
//   extReset  asynchronous active-low reset
//   bus       spi_rx_frontend_if.slave (SPI pins, command and metadata outputs)
//
// Build option: define SPI_META_EN to build the metadata FSM and table.
// Without it writeMeta/meta_data are tied to 0 and query_metadata/xmit_idle
// are ignored.
// -----------------------------------------------------------------------------
module spi_rx_frontend (
    input  logic               clock,
    input  logic               extReset,
    spi_rx_frontend_if.slave   bus
);

    // ---- stage p0/p1: two-flop synchronizers, p2: sclk edge history ----
    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1;

    always_ff @(posedge clock or negedge extReset) begin
        if (!extReset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
        end else begin
            sclk_p0 <= bus.sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= bus.cs;
            cs_p1   <= cs_p0;
        end
    end

    assign bus.sync_sclk = sclk_p1;
    assign bus.sync_cs   = cs_p1;

    // ---- byte assembly on synchronized sclk rising edges ----
    logic       sclk_rise;
    logic [7:0] shift_reg;
    logic [7:0] byte_next;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic       byte_ok;

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign byte_next = {shift_reg[6:0], bus.mosi};
    assign byte_done = sclk_rise & ~cs_p1 & (bit_cnt == 3'd7);
    // A byte finished while the transmitter is busy is simply dropped.
    assign byte_ok   = byte_done & ~bus.transmitting;

    always_ff @(posedge clock or negedge extReset) begin
        if (!extReset) begin
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
        end else if (cs_p1) begin
            bit_cnt   <= 3'd0;
        end else if (sclk_rise) begin
            shift_reg <= byte_next;
            bit_cnt   <= bit_cnt + 3'd1;
        end
    end

    // ---- command FSM ----
    typedef enum logic [1:0] {OPCODE, ARG, EXEC} cmd_state_t;

    cmd_state_t  cmd_state, cmd_next;
    logic [1:0]  arg_cnt;
    logic        load_op;
    logic        load_arg;
    logic        execute;
    logic [7:0]  op_q;
    logic [31:0] data_q;

    always_ff @(posedge clock or negedge extReset) begin
        if (!extReset) begin
            cmd_state <= OPCODE;
        end else begin
            cmd_state <= cmd_next;
        end
    end

    always_comb begin
        cmd_next = cmd_state;
        load_op  = 1'b0;
        load_arg = 1'b0;
        execute  = 1'b0;
        case (cmd_state)
            OPCODE: begin
                if (byte_ok) begin
                    load_op  = 1'b1;
                    cmd_next = byte_next[7] ? ARG : EXEC;
                end
            end
            ARG: begin
                if (byte_ok) begin
                    load_arg = 1'b1;
                    if (arg_cnt == 2'd3) begin
                        cmd_next = EXEC;
                    end
                end
            end
            EXEC: begin
                execute  = 1'b1;
                cmd_next = OPCODE;
            end
            default: cmd_next = OPCODE;
        endcase
        // Deselect abandons any frame in progress.
        if (cs_p1) begin
            cmd_next = OPCODE;
        end
    end

    always_ff @(posedge clock or negedge extReset) begin
        if (!extReset) begin
            arg_cnt <= 2'd0;
            op_q    <= 8'h00;
            data_q  <= 32'h0;
        end else begin
            if (load_op || cs_p1) begin
                arg_cnt <= 2'd0;
            end else if (load_arg) begin
                arg_cnt <= arg_cnt + 2'd1;
            end
            if (load_op) begin
                op_q <= byte_next;
            end
            // Argument arrives least-significant byte first.
            if (load_arg) begin
                data_q <= {byte_next, data_q[31:8]};
            end
        end
    end

    assign bus.op      = op_q;
    assign bus.data    = data_q;
    assign bus.execute = execute;

`ifdef SPI_META_EN
    // ---- metadata streamer ----
    typedef enum logic [1:0] {IDLE, SEND, WAIT} meta_state_t;

    meta_state_t meta_state, meta_next;
    logic [4:0]  meta_index;
    logic        index_clr;
    logic        send_fire;
    logic        write_meta_q;
    logic [7:0]  meta_data_q;

    function automatic logic [7:0] meta_rom(input logic [4:0] idx);
        case (idx)
            5'd0:  meta_rom = 8'h01;
            5'd1:  meta_rom = 8'h42;  // 'B'
            5'd2:  meta_rom = 8'h50;  // 'P'
            5'd3:  meta_rom = 8'h4C;  // 'L'
            5'd4:  meta_rom = 8'h53;  // 'S'
            5'd5:  meta_rom = 8'h00;
            5'd6:  meta_rom = 8'h02;
            5'd7:  meta_rom = 8'h33;  // '3'
            5'd8:  meta_rom = 8'h2E;  // '.'
            5'd9:  meta_rom = 8'h30;  // '0'
            5'd10: meta_rom = 8'h37;  // '7'
            5'd11: meta_rom = 8'h00;
            5'd12: meta_rom = 8'h21;
            5'd13: meta_rom = 8'h00;
            5'd14: meta_rom = 8'h00;
            5'd15: meta_rom = 8'h60;
            5'd16: meta_rom = 8'h00;
            5'd17: meta_rom = 8'h23;
            5'd18: meta_rom = 8'h05;
            5'd19: meta_rom = 8'hF5;
            5'd20: meta_rom = 8'hE1;
            5'd21: meta_rom = 8'h00;
            5'd22: meta_rom = 8'h40;
            5'd23: meta_rom = 8'h20;
            5'd24: meta_rom = 8'h41;
            5'd25: meta_rom = 8'h02;
            default: meta_rom = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clock or negedge extReset) begin
        if (!extReset) begin
            meta_state <= IDLE;
        end else begin
            meta_state <= meta_next;
        end
    end

    always_comb begin
        meta_next = meta_state;
        index_clr = 1'b0;
        send_fire = 1'b0;
        case (meta_state)
            IDLE: begin
                if (bus.query_metadata) begin
                    index_clr = 1'b1;
                    meta_next = SEND;
                end
            end
            SEND: begin
                if (bus.xmit_idle) begin
                    send_fire = 1'b1;
                    meta_next = (meta_index == 5'd26) ? IDLE : WAIT;
                end
            end
            WAIT: begin
                // Wait for the transmitter to take the byte before offering the next.
                if (!bus.xmit_idle) begin
                    meta_next = SEND;
                end
            end
            default: meta_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge extReset) begin
        if (!extReset) begin
            meta_index   <= 5'd0;
            write_meta_q <= 1'b0;
            meta_data_q  <= 8'h00;
        end else begin
            if (index_clr) begin
                meta_index <= 5'd0;
            end else if (send_fire) begin
                meta_index <= meta_index + 5'd1;
            end
            write_meta_q <= send_fire;
            if (send_fire) begin
                meta_data_q <= meta_rom(meta_index);
            end
        end
    end

    assign bus.writeMeta = write_meta_q;
    assign bus.meta_data = meta_data_q;
`else
    logic unused_meta;
    assign unused_meta   = bus.query_metadata ^ bus.xmit_idle;
    assign bus.writeMeta = 1'b0;
    assign bus.meta_data = 8'h00;
`endif

endmodule

// File: tb/tb_spi_rx_frontend.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_frontend
// Directed-vector bench for spi_rx_frontend: command frames, cs abort,
// transmitting discard, reset, and (with SPI_META_EN) the metadata stream.
// -----------------------------------------------------------------------------
module tb_spi_rx_frontend;

    logic clock;
    logic extReset;
    int   n_vec;
    int   n_err;
    int   exec_cnt;
    int   meta_cnt;

    spi_rx_frontend_if bus ();

    spi_rx_frontend dut (
        .clock    (clock),
        .extReset (extReset),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.execute)   exec_cnt++;
        if (bus.writeMeta) meta_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Mode-0 SPI: mosi set while sclk low, sampled on rise; top n bits, MSB first.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.mosi = b[7-i];
            bus.sclk = 1'b0;
            tick(4);
            bus.sclk = 1'b1;
            tick(4);
        end
        bus.sclk = 1'b0;
        tick(6);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic wait_meta(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (bus.writeMeta) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

`ifdef SPI_META_EN
    logic [7:0] exp_meta [27] = '{
        8'h01, 8'h42, 8'h50, 8'h4C, 8'h53, 8'h00,
        8'h02, 8'h33, 8'h2E, 8'h30, 8'h37, 8'h00,
        8'h21, 8'h00, 8'h00, 8'h60, 8'h00,
        8'h23, 8'h05, 8'hF5, 8'hE1, 8'h00,
        8'h40, 8'h20,
        8'h41, 8'h02,
        8'h00
    };
`endif

    initial begin
        int e0;
        int m0;
        bit ok;
        n_vec    = 0;
        n_err    = 0;
        exec_cnt = 0;
        meta_cnt = 0;

        // Reset state
        extReset           = 1'b0;
        bus.sclk           = 1'b0;
        bus.cs             = 1'b1;
        bus.mosi           = 1'b0;
        bus.transmitting   = 1'b0;
        bus.query_metadata = 1'b0;
        bus.xmit_idle      = 1'b0;
        tick(3);
        chk("rst_sync_sclk", bus.sync_sclk, 1'b0);
        chk("rst_sync_cs",   bus.sync_cs,   1'b1);
        chk("rst_op",        bus.op,        8'h00);
        chk("rst_data",      bus.data,      32'h0);
        chk("rst_execute",   bus.execute,   1'b0);
        chk("rst_writeMeta", bus.writeMeta, 1'b0);
        chk("rst_meta_data", bus.meta_data, 8'h00);
        extReset = 1'b1;
        tick(2);

        // Synchronizer latency: two clocks
        bus.sclk = 1'b1;
        tick(1);
        chk("sclk_lag1", bus.sync_sclk, 1'b0);
        tick(1);
        chk("sclk_lag2", bus.sync_sclk, 1'b1);
        bus.sclk = 1'b0;
        tick(4);
        bus.cs = 1'b0;
        tick(1);
        chk("cs_lag1", bus.sync_cs, 1'b1);
        tick(1);
        chk("cs_lag2", bus.sync_cs, 1'b0);
        tick(2);

        // Short command 0x01
        e0 = exec_cnt;
        send_byte(8'h01);
        chk("short_op",   bus.op,         8'h01);
        chk("short_data", bus.data,       32'h0);
        chk("short_exec", exec_cnt - e0,  1);

        // Long command 0x80 + 11 22 33 44
        e0 = exec_cnt;
        send_byte(8'h80);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chk("long_exec_early", exec_cnt - e0, 0);
        send_byte(8'h44);
        chk("long_op",   bus.op,        8'h80);
        chk("long_data", bus.data,      32'h44332211);
        chk("long_exec", exec_cnt - e0, 1);

        // Aborted long command, then short 0x02
        e0 = exec_cnt;
        send_byte(8'h80);
        send_byte(8'hAA);
        send_byte(8'hBB);
        bus.cs = 1'b1;
        tick(6);
        chk("abort_exec", exec_cnt - e0, 0);
        bus.cs = 1'b0;
        tick(4);
        send_byte(8'h02);
        chk("abort_op",   bus.op,        8'h02);
        chk("abort_data", bus.data,      32'hBBAA4433);
        chk("abort_exec2", exec_cnt - e0, 1);

        // Partial byte discarded on deselect
        e0 = exec_cnt;
        send_bits(8'hF0, 4);
        bus.cs = 1'b1;
        tick(6);
        bus.cs = 1'b0;
        tick(4);
        send_byte(8'h03);
        chk("partial_op",   bus.op,        8'h03);
        chk("partial_exec", exec_cnt - e0, 1);

        // Byte dropped while transmitting
        e0 = exec_cnt;
        bus.transmitting = 1'b1;
        send_byte(8'h00);
        bus.transmitting = 1'b0;
        tick(4);
        chk("xmit_exec", exec_cnt - e0, 0);
        chk("xmit_op",   bus.op,        8'h03);
        send_byte(8'h06);
        chk("xmit_after_op",   bus.op,        8'h06);
        chk("xmit_after_exec", exec_cnt - e0, 1);

        // Reset mid-frame
        e0 = exec_cnt;
        send_byte(8'h80);
        send_byte(8'h12);
        send_bits(8'h34, 4);
        extReset = 1'b0;
        tick(2);
        chk("midrst_op",   bus.op,   8'h00);
        chk("midrst_data", bus.data, 32'h0);
        extReset = 1'b1;
        tick(6);
        chk("midrst_exec", exec_cnt - e0, 0);
        send_byte(8'h05);
        chk("postrst_op",   bus.op,        8'h05);
        chk("postrst_data", bus.data,      32'h0);
        chk("postrst_exec", exec_cnt - e0, 1);
        bus.cs = 1'b1;
        tick(4);

`ifdef SPI_META_EN
        // Full metadata stream
        bus.xmit_idle      = 1'b1;
        bus.query_metadata = 1'b1;
        tick(1);
        bus.query_metadata = 1'b0;
        for (int k = 0; k < 27; k++) begin
            wait_meta(ok);
            chk($sformatf("meta_strobe%0d", k), ok, 1'b1);
            if (!ok) break;
            chk($sformatf("meta_byte%0d", k), bus.meta_data, exp_meta[k]);
            bus.xmit_idle = 1'b0;
            if (k == 5) begin
                // Request while busy must not restart the table.
                bus.query_metadata = 1'b1;
                tick(1);
                bus.query_metadata = 1'b0;
                tick(1);
            end else begin
                tick(2);
            end
            if (k == 0) chk("meta_hold", bus.meta_data, 8'h01);
            bus.xmit_idle = 1'b1;
        end
        m0 = meta_cnt;
        tick(30);
        chk("meta_idle_after", meta_cnt - m0, 0);

        // Reset after three bytes, then restart
        bus.query_metadata = 1'b1;
        tick(1);
        bus.query_metadata = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_meta(ok);
            chk($sformatf("mrst_strobe%0d", k), ok, 1'b1);
            if (!ok) break;
            chk($sformatf("mrst_byte%0d", k), bus.meta_data, exp_meta[k]);
            bus.xmit_idle = 1'b0;
            tick(2);
            bus.xmit_idle = 1'b1;
            if (k == 2) bus.xmit_idle = 1'b0;
        end
        extReset = 1'b0;
        m0 = meta_cnt;
        tick(3);
        chk("mrst_writeMeta", bus.writeMeta, 1'b0);
        chk("mrst_meta_data", bus.meta_data, 8'h00);
        extReset = 1'b1;
        bus.xmit_idle = 1'b1;
        tick(30);
        chk("mrst_no_strobe", meta_cnt - m0, 0);
        bus.query_metadata = 1'b1;
        tick(1);
        bus.query_metadata = 1'b0;
        wait_meta(ok);
        chk("mrst_restart_strobe", ok, 1'b1);
        chk("mrst_restart_byte", bus.meta_data, 8'h01);
        bus.xmit_idle = 1'b0;
        tick(4);
`else
        // Metadata not built: requests have no effect
        m0 = meta_cnt;
        bus.xmit_idle      = 1'b1;
        bus.query_metadata = 1'b1;
        tick(1);
        bus.query_metadata = 1'b0;
        tick(40);
        chk("nometa_strobes", meta_cnt - m0, 0);
        chk("nometa_data",    bus.meta_data, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_rx_frontend.md
SPI_RX_FRONTEND -- requirements
Module: spi_rx_frontend

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clock input 1 (rising-edge system clock); extReset input 1 (asynchronous, active-low reset).
REQ-002 SHALL have inputs sclk 1 (raw SPI clock), cs 1 (raw chip select, active-low), mosi 1 (serial data in), transmitting 1 (high while the transmitter is busy), query_metadata 1 (one-cycle metadata request), xmit_idle 1 (high when the transmitter can accept a byte).
REQ-003 SHALL have outputs sync_sclk 1 and sync_cs 1 (synchronized sclk/cs), op 8 (opcode), data 32 (command argument), execute 1 (command-valid strobe), writeMeta 1 (metadata byte strobe), meta_data 8 (metadata byte).

Function
REQ-004 sclk and cs SHALL each pass through a 2-flop synchronizer; sync outputs lag the input by 2 clocks.
REQ-005 An sclk rising edge SHALL be detected as sync_sclk=1 while its previous-cycle value was 0; mosi SHALL be sampled on that cycle.
REQ-006 Bits SHALL shift MSB-first into an 8-bit byte register; a 3-bit counter SHALL complete a byte after 8 edges.
REQ-007 sync_cs=1 SHALL clear the bit counter and return the state machine to OPCODE; partial bytes SHALL be discarded.
REQ-008 States SHALL be OPCODE, ARG, EXEC; in OPCODE a completed byte SHALL load op.
REQ-009 If op bit7=0 (short command), the next state SHALL be EXEC; otherwise it SHALL be ARG, which collects 4 bytes.
REQ-010 Argument bytes SHALL arrive LSB-byte first: each byte SHALL shift in as data <= {byte, data[31:8]}.
REQ-011 EXEC SHALL assert execute for exactly one clock, then return to OPCODE; op/data SHALL hold until the next command overwrites them.
REQ-012 Bytes completed while transmitting=1 SHALL be discarded without a state change.
REQ-013 Metadata SHALL be a fixed 27-byte table (indices 0..26): 01 'B' 'P' 'L' 'S' 00 | 02 '3' '.' '0' '7' 00 | 21 00 00 60 00 | 23 05 F5 E1 00 | 40 20 | 41 02 | 00.
REQ-014 The metadata FSM SHALL have states IDLE, SEND, WAIT; query_metadata in IDLE SHALL set index to 0 and move to SEND.
REQ-015 In SEND with xmit_idle=1, writeMeta SHALL pulse 1 clock with meta_data=table[index]; index SHALL increment and the FSM SHALL move to WAIT.
REQ-016 WAIT SHALL return to SEND once xmit_idle=0 has been observed for at least one clock; after index 26 is sent, the FSM SHALL go to IDLE.
REQ-017 query_metadata outside IDLE SHALL be ignored.
REQ-018 meta_data SHALL hold its last value between strobes.

Reset
REQ-019 While extReset=0: sclk sync flops SHALL be 0, cs sync flops 1, op=0, data=0, execute=0, writeMeta=0, meta_data=0, both FSMs in their initial state (OPCODE / IDLE), counters and index 0.
REQ-020 Reset mid-frame or mid-metadata SHALL abort the operation with no execute or writeMeta pulse.

Configuration
REQ-021 With SPI_META_EN defined, the metadata FSM and table SHALL be built; without it, writeMeta and meta_data SHALL be constant 0 and query_metadata and xmit_idle SHALL be ignored.

Verification
REQ-022 cs low, send byte 0x01 -> op=0x01, data unchanged, one execute pulse.
REQ-023 Send 0x80 then bytes 11 22 33 44 -> op=0x80, data=0x44332211, one execute pulse after the 5th byte.
REQ-024 Send 0x80 plus 2 argument bytes, raise cs, then send 0x02 -> no execute for 0x80, op=0x02, one execute pulse.
REQ-025 Send 0x00 with transmitting=1 -> no execute, op unchanged.
REQ-026 query_metadata pulse, bench toggles xmit_idle after each writeMeta -> 27 strobes with bytes 01 42 50 4C 53 00 ... 41 02 00, then FSM idle.
REQ-027 Assert extReset after 3 metadata bytes -> writeMeta stays 0, and a new query_metadata restarts the sequence at 0x01.
